// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and the
// 4-input LUT init words that realise the single full-adder cell.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // LUT index is {I3,I2,I1,I0}; I3 is tied low so both halves match.
  localparam logic [15:0] SUM_LUT_INIT   = 16'h9696;
  localparam logic [15:0] CARRY_LUT_INIT = 16'hE8E8;

endpackage

// File: rtl/fa_cell.sv
// One full-adder bit built from two LUT lookups (sum and carry), the
// cell the serial adder time-multiplexes over the operand width.
module fa_cell
  import serial_adder_pkg::*;
(
  input  logic I0,
  input  logic I1,
  input  logic CIN,
  output logic O,
  output logic COUT
);

  logic [3:0] idx;

  assign idx  = {1'b0, CIN, I1, I0};
  assign O    = SUM_LUT_INIT[idx];
  assign COUT = CARRY_LUT_INIT[idx];

endmodule

// File: rtl/serial_adder_stream.sv
// Bit-serial adder, LSB first, one bit per clock with a registered carry;
// valid/ready handshake on operand and result sides.
module serial_adder_stream
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_nx;
  logic             c;
  logic             fa_o, fa_co;
  logic             last;

  fa_cell u_fa (
    .I0   (a_sh[0]),
    .I1   (b_sh[0]),
    .CIN  (c),
    .O    (fa_o),
    .COUT (fa_co)
  );

  assign last = (count == CNT_W'(WIDTH - 1));

  // Shift written without a slice so WIDTH=1 stays legal.
  always_comb begin
    s_nx            = s_sh >> 1;
    s_nx[WIDTH-1]   = fa_o;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (I_VALID) state_nx = RUN;
      RUN:     if (last)    state_nx = DONE;
      DONE:    if (O_READY) state_nx = IDLE;
      default:              state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state <= IDLE;
      count <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      c     <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (I_VALID) begin
          a_sh  <= A;
          b_sh  <= B;
          c     <= CIN;
          count <= '0;
          s_sh  <= '0;
        end
        RUN: begin
          s_sh  <= s_nx;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          c     <= fa_co;
          count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign I_READY = (state == IDLE);
  assign O_VALID = (state == DONE);
  assign SUM     = s_sh;
  assign COUT    = c;

endmodule

// File: tb/tb_serial_adder_stream.sv
// Directed bench: WIDTH=8 and WIDTH=1 instances sharing clock and reset.
module tb_serial_adder_stream;

  logic CLK = 1'b0;
  logic ASYNCRESETN;

  logic       I_VALID8, I_READY8, CIN8, O_VALID8, O_READY8, COUT8;
  logic [7:0] A8, B8, SUM8;
  logic       I_VALID1, I_READY1, CIN1, O_VALID1, O_READY1, COUT1;
  logic [0:0] A1, B1, SUM1;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  serial_adder_stream #(.WIDTH(8)) dut8 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .I_VALID(I_VALID8), .I_READY(I_READY8), .A(A8), .B(B8), .CIN(CIN8),
    .O_VALID(O_VALID8), .O_READY(O_READY8), .SUM(SUM8), .COUT(COUT8)
  );

  serial_adder_stream #(.WIDTH(1)) dut1 (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .I_VALID(I_VALID1), .I_READY(I_READY1), .A(A1), .B(B1), .CIN(CIN1),
    .O_VALID(O_VALID1), .O_READY(O_READY1), .SUM(SUM1), .COUT(COUT1)
  );

  typedef struct {
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge CLK);
    A8 = a; B8 = b; CIN8 = cin; I_VALID8 = 1'b1;
    @(posedge CLK); #1;
    I_VALID8 = 1'b0;
  endtask

  // Counts edges after the accept until O_VALID, bounded.
  task automatic wait8(output int lat, output bit rdy_low);
    lat = 0; rdy_low = 1'b1;
    while (!O_VALID8 && lat < 40) begin
      if (I_READY8) rdy_low = 1'b0;
      @(posedge CLK); #1;
      lat++;
    end
    if (I_READY8) rdy_low = 1'b0;
  endtask

  task automatic ack8();
    @(negedge CLK);
    O_READY8 = 1'b1;
    @(posedge CLK); #1;
    O_READY8 = 1'b0;
    chk("ack8_ovalid_drop", O_VALID8, 1'b0);
    chk("ack8_iready_back", I_READY8, 1'b1);
  endtask

  initial begin
    vec_t v8[6];
    vec_t v1[4];
    int   lat;
    bit   rl;

    v8[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
    v8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    v8[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    v8[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    v8[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
    v8[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    v1[0] = '{8'h1, 8'h1, 1'b1, 8'h1, 1'b1};
    v1[1] = '{8'h1, 8'h0, 1'b0, 8'h1, 1'b0};
    v1[2] = '{8'h0, 8'h0, 1'b0, 8'h0, 1'b0};
    v1[3] = '{8'h0, 8'h1, 1'b1, 8'h0, 1'b1};

    ASYNCRESETN = 1'b0;
    I_VALID8 = 0; A8 = 0; B8 = 0; CIN8 = 0; O_READY8 = 0;
    I_VALID1 = 0; A1 = 0; B1 = 0; CIN1 = 0; O_READY1 = 0;
    #12;
    chk("rst_ovalid8", O_VALID8, 1'b0);
    chk("rst_sum8",    SUM8,     8'h00);
    chk("rst_cout8",   COUT8,    1'b0);
    chk("rst_iready8", I_READY8, 1'b1);
    chk("rst_ovalid1", O_VALID1, 1'b0);
    chk("rst_iready1", I_READY1, 1'b1);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;

    for (int i = 0; i < 6; i++) begin
      start8(v8[i].a, v8[i].b, v8[i].cin);
      wait8(lat, rl);
      chk($sformatf("v8[%0d]_sum", i),  SUM8,  v8[i].sum);
      chk($sformatf("v8[%0d]_cout", i), COUT8, v8[i].cout);
      chk($sformatf("v8[%0d]_lat", i),  lat,   8);
      chk($sformatf("v8[%0d]_irdy_low", i), rl, 1'b1);
      ack8();
    end

    // Backpressure: result held while new operands are offered.
    start8(8'h5A, 8'h33, 1'b0);
    wait8(lat, rl);
    @(negedge CLK);
    I_VALID8 = 1'b1; A8 = 8'h01; B8 = 8'h01; CIN8 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("bp%0d_ovalid", k), O_VALID8, 1'b1);
      chk($sformatf("bp%0d_sum", k),    {COUT8, SUM8}, 9'h08D);
      chk($sformatf("bp%0d_iready", k), I_READY8, 1'b0);
    end
    @(negedge CLK);
    I_VALID8 = 1'b0;
    ack8();
    start8(8'h01, 8'h01, 1'b0);
    wait8(lat, rl);
    chk("bp_next_sum", {COUT8, SUM8}, 9'h002);
    ack8();

    // Operands change right after the accept; result must not follow.
    start8(8'h10, 8'h20, 1'b0);
    A8 = 8'h00; B8 = 8'h00;
    wait8(lat, rl);
    chk("holdoff_sum", {COUT8, SUM8}, 9'h030);
    ack8();

    // Reset mid-RUN, then accept on the first edge after release.
    start8(8'hFF, 8'hFF, 1'b1);
    repeat (3) @(posedge CLK);
    #2 ASYNCRESETN = 1'b0;
    #1;
    chk("rrun_ovalid", O_VALID8, 1'b0);
    chk("rrun_sum",    SUM8,     8'h00);
    chk("rrun_cout",   COUT8,    1'b0);
    chk("rrun_iready", I_READY8, 1'b1);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    A8 = 8'h7F; B8 = 8'h01; CIN8 = 1'b0; I_VALID8 = 1'b1;
    @(posedge CLK); #1;
    I_VALID8 = 1'b0;
    chk("rrun_accept", I_READY8, 1'b0);
    wait8(lat, rl);
    chk("rrun_after_sum", {COUT8, SUM8}, 9'h080);
    chk("rrun_after_lat", lat, 8);
    ack8();

    // Reset while a result is pending.
    start8(8'h0F, 8'h01, 1'b0);
    wait8(lat, rl);
    #2 ASYNCRESETN = 1'b0;
    #1;
    chk("rdone_ovalid", O_VALID8, 1'b0);
    chk("rdone_sum",    SUM8,     8'h00);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      A1 = v1[i].a[0]; B1 = v1[i].b[0]; CIN1 = v1[i].cin; I_VALID1 = 1'b1;
      @(posedge CLK); #1;
      I_VALID1 = 1'b0;
      lat = 0;
      while (!O_VALID1 && lat < 10) begin
        @(posedge CLK); #1;
        lat++;
      end
      chk($sformatf("v1[%0d]_sum", i),  SUM1,  v1[i].sum[0]);
      chk($sformatf("v1[%0d]_cout", i), COUT1, v1[i].cout);
      chk($sformatf("v1[%0d]_lat", i),  lat,   1);
      @(negedge CLK);
      O_READY1 = 1'b1;
      @(posedge CLK); #1;
      O_READY1 = 1'b0;
      chk($sformatf("v1[%0d]_iready", i), I_READY1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
